// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester-side and transmitter-side handshake bundle for uart_tx_scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0] reqValid;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0] reqParityErrInj;
    logic [NUM_REQ-1:0] reqReady;
    logic txValid;
    logic [DATA_WIDTH-1:0] txData;
    logic txParityErrInj;
    logic txReady;
    logic txDone;
    modport master (
        input reqValid, reqData, reqParityErrInj, txReady, txDone,
        output reqReady, txValid, txData, txParityErrInj
    );
    modport slave (
        output reqValid, reqData, reqParityErrInj, txReady, txDone,
        input reqReady, txValid, txData, txParityErrInj
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter between NUM_REQ requesters,
// with inter-frame gap, completed-packet counter and completion timeout.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    uart_tx_scheduler_if.master bus,
    output logic [$clog2(NUM_REQ)-1:0] grantId,
    output logic busy,
    output logic [15:0] packetCount,
    output logic timeoutErr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
    localparam state_t AFTER = (GAP_CYCLES == 0) ? IDLE : GAP;
    state_t state;
    state_t stateNext;
    logic [IW-1:0] rrPtr;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;
    logic [DATA_WIDTH-1:0] selData;
    logic selInj;
    logic grant;
    logic done;
    logic abort;
    logic [TW-1:0] toCnt;
    logic [GW-1:0] gapCnt;
    // Scan from the farthest offset back to rrPtr so the nearest requester wins.
    always_comb begin
        winner = rrPtr;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rrPtr) + k) % NUM_REQ);
            if (bus.reqValid[idx]) winner = idx;
        end
    end
    always_comb begin
        selData = '0;
        selInj = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == winner) begin
                selData = bus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
                selInj = bus.reqParityErrInj[i];
            end
        end
    end
    assign grant = state == IDLE && enable && |bus.reqValid;
    assign bus.reqReady = grant ? NUM_REQ'(1) << winner : '0;
    assign bus.txValid = state == ISSUE;
    assign busy = state != IDLE;
    assign done = state == WAIT_DONE && bus.txDone;
    // txDone on the limit cycle counts as completion, not as a timeout.
    assign abort = state == WAIT_DONE && !bus.txDone && toCnt == TW'(TIMEOUT_CYCLES - 1);
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      stateNext = grant ? ISSUE : IDLE;
            ISSUE:     stateNext = bus.txReady ? WAIT_DONE : ISSUE;
            WAIT_DONE: stateNext = (done || abort) ? AFTER : WAIT_DONE;
            GAP:       stateNext = gapCnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
            default:   stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rrPtr <= '0;
            grantId <= '0;
            bus.txData <= '0;
            bus.txParityErrInj <= 1'b0;
            packetCount <= '0;
            timeoutErr <= 1'b0;
            toCnt <= '0;
            gapCnt <= '0;
        end else begin
            state <= stateNext;
            timeoutErr <= abort;
            toCnt <= state == WAIT_DONE ? toCnt + 1'b1 : '0;
            gapCnt <= state == GAP ? gapCnt + 1'b1 : '0;
            if (grant) begin
                bus.txData <= selData;
                bus.txParityErrInj <= selInj;
                grantId <= winner;
                rrPtr <= winner == IW'(NUM_REQ - 1) ? '0 : winner + 1'b1;
            end
            if (done) packetCount <= packetCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized scenario tests of uart_tx_scheduler against a round-robin reference model.
module tb_uart_tx_scheduler;
    localparam int N = 4;
    localparam int DW = 8;
    localparam int GAP = 2;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic [1:0] grantId;
    logic busy;
    logic [15:0] packetCount;
    logic timeoutErr;
    int total = 0;
    int bad = 0;
    int ptr = 0;
    int expCount = 0;

    uart_tx_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus),
        .grantId(grantId), .busy(busy), .packetCount(packetCount), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    // Reference arbitration: nearest valid requester at or after the pointer, wrapping.
    function automatic int rrWin(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Driver only: from the first WAIT_DONE cycle, pulse txDone after 'delay' cycles and sit out the gap.
    task automatic finishFrame(input int delay);
        repeat (delay) @(negedge clk);
        bus.txDone = 1'b1;
        @(negedge clk);
        bus.txDone = 1'b0;
        expCount++;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic test_reset;
        bus.reqValid = '0;
        bus.reqData = '0;
        bus.reqParityErrInj = '0;
        bus.txReady = 1'b0;
        bus.txDone = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.reqReady, bus.txValid, bus.txData, bus.txParityErrInj, grantId, busy, packetCount, timeoutErr} !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", {bus.reqReady, bus.txValid, bus.txData, bus.txParityErrInj, grantId, busy, packetCount, timeoutErr});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int w;
        enable = 1'b1;
        bus.txReady = 1'b1;
        bus.reqData[7:0] = 8'hA5;
        bus.reqParityErrInj = '0;
        bus.reqValid = 4'b0001;
        #1;
        w = rrWin(bus.reqValid);
        total++;
        if (bus.reqReady !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", bus.reqReady); end
        ptr = (w + 1) % N;
        @(negedge clk);
        bus.reqValid = '0;
        total++;
        if ({bus.txValid, bus.txData, grantId, bus.reqReady} !== {1'b1, 8'hA5, 2'd0, 4'b0000}) begin
            bad++;
            $display("FAIL single_issue: got v=%b d=%h id=%0d rdy=%b want v=1 d=a5 id=0 rdy=0000", bus.txValid, bus.txData, grantId, bus.reqReady);
        end
        @(negedge clk);
        total++;
        if ({bus.txValid, busy} !== 2'b01) begin bad++; $display("FAIL single_handshake: got txValid=%b busy=%b want 0 1", bus.txValid, busy); end
        repeat (9) @(negedge clk);
        bus.txDone = 1'b1;
        @(negedge clk);
        bus.txDone = 1'b0;
        expCount++;
        total++;
        if ({packetCount, busy} !== {16'(expCount), 1'b1}) begin bad++; $display("FAIL single_count: got cnt=%0d busy=%b want cnt=%0d busy=1", packetCount, busy, expCount); end
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_gap: got busy=%b want 1", busy); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin;
        int w;
        logic [N-1:0] er;
        logic [N-1:0] seen;
        seen = '0;
        bus.txReady = 1'b1;
        bus.reqData = 32'h13121110;
        bus.reqValid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            #1;
            w = rrWin(bus.reqValid);
            er = N'(1) << w;
            if (seen == '1) seen = '0;
            total++;
            if (bus.reqReady !== er) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", f, bus.reqReady, er); end
            total++;
            if ((bus.reqReady & seen) !== '0) begin bad++; $display("FAIL rr_repeat[%0d]: got %b already granted %b", f, bus.reqReady, seen); end
            seen = seen | er;
            ptr = (w + 1) % N;
            @(negedge clk);
            total++;
            if ({bus.txValid, bus.txData, grantId, bus.reqReady} !== {1'b1, 8'(8'h10 + w), 2'(w), 4'b0000}) begin
                bad++;
                $display("FAIL rr_issue[%0d]: got v=%b d=%h id=%0d rdy=%b want v=1 d=%h id=%0d rdy=0000", f, bus.txValid, bus.txData, grantId, bus.reqReady, 8'(8'h10 + w), w);
            end
            @(negedge clk);
            finishFrame($urandom_range(0, 5));
        end
        bus.reqValid = '0;
        total++;
        if (packetCount !== 16'(expCount)) begin bad++; $display("FAIL rr_count: got %0d want %0d", packetCount, expCount); end
    endtask

    task automatic test_backpressure;
        int w;
        logic [DW-1:0] ed;
        logic ei;
        bus.txReady = 1'b0;
        bus.reqData = $urandom;
        bus.reqParityErrInj = N'($urandom);
        bus.reqValid = N'($urandom_range(1, 15));
        #1;
        w = rrWin(bus.reqValid);
        ed = bus.reqData[w*DW +: DW];
        ei = bus.reqParityErrInj[w];
        total++;
        if (bus.reqReady !== N'(1) << w) begin bad++; $display("FAIL bp_ready: got %b want %b", bus.reqReady, N'(1) << w); end
        ptr = (w + 1) % N;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({bus.txValid, bus.txData, bus.txParityErrInj, bus.reqReady} !== {1'b1, ed, ei, 4'b0000}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h p=%b rdy=%b want v=1 d=%h p=%b rdy=0000", k, bus.txValid, bus.txData, bus.txParityErrInj, bus.reqReady, ed, ei);
            end
            @(negedge clk);
        end
        bus.txReady = 1'b1;
        @(negedge clk);
        bus.reqValid = '0;
        total++;
        if ({bus.txValid, busy} !== 2'b01) begin bad++; $display("FAIL bp_handshake: got txValid=%b busy=%b want 0 1", bus.txValid, busy); end
        finishFrame($urandom_range(0, 6));
    endtask

    task automatic test_enable_low;
        enable = 1'b0;
        bus.reqValid = 4'b1111;
        bus.txDone = 1'b1;
        #1;
        total++;
        if (bus.reqReady !== 4'b0000) begin bad++; $display("FAIL en_low_ready: got %b want 0000", bus.reqReady); end
        @(negedge clk);
        bus.txDone = 1'b0;
        total++;
        if ({busy, packetCount} !== {1'b0, 16'(expCount)}) begin bad++; $display("FAIL en_low_idle: got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, packetCount, expCount); end
        bus.reqValid = '0;
        enable = 1'b1;
    endtask

    task automatic test_timeout;
        int w;
        int pulses;
        int first;
        bus.txReady = 1'b1;
        bus.reqValid = N'($urandom_range(1, 15));
        #1;
        w = rrWin(bus.reqValid);
        ptr = (w + 1) % N;
        @(negedge clk);
        bus.reqValid = '0;
        @(negedge clk);
        pulses = 0;
        first = -1;
        for (int k = 0; k <= 20; k++) begin
            if (timeoutErr === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            @(negedge clk);
        end
        total++;
        if (first !== 16 || pulses !== 1) begin bad++; $display("FAIL timeout_pulse: got first=%0d pulses=%0d want first=16 pulses=1", first, pulses); end
        total++;
        if ({packetCount, busy} !== {16'(expCount), 1'b0}) begin bad++; $display("FAIL timeout_count: got cnt=%0d busy=%b want cnt=%0d busy=0", packetCount, busy, expCount); end
        bus.reqValid = N'($urandom_range(1, 15));
        #1;
        w = rrWin(bus.reqValid);
        total++;
        if (bus.reqReady !== N'(1) << w) begin bad++; $display("FAIL timeout_next: got %b want %b", bus.reqReady, N'(1) << w); end
        bus.reqValid = '0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL drop_no_grant: got busy=%b want 0", busy); end
    endtask

    task automatic test_random;
        int w;
        int st;
        logic [DW-1:0] ed;
        logic ei;
        for (int it = 0; it < 20; it++) begin
            st = $urandom_range(0, 3);
            bus.txReady = (st == 0);
            bus.reqData = $urandom;
            bus.reqParityErrInj = N'($urandom);
            bus.reqValid = N'($urandom_range(1, 15));
            #1;
            w = rrWin(bus.reqValid);
            ed = bus.reqData[w*DW +: DW];
            ei = bus.reqParityErrInj[w];
            total++;
            if (bus.reqReady !== N'(1) << w) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", it, bus.reqReady, N'(1) << w); end
            ptr = (w + 1) % N;
            @(negedge clk);
            bus.reqValid = N'($urandom);
            bus.reqData = $urandom;
            #1;
            total++;
            if ({bus.txValid, bus.txData, bus.txParityErrInj, grantId} !== {1'b1, ed, ei, 2'(w)}) begin
                bad++;
                $display("FAIL rand_issue[%0d]: got v=%b d=%h p=%b id=%0d want v=1 d=%h p=%b id=%0d", it, bus.txValid, bus.txData, bus.txParityErrInj, grantId, ed, ei, w);
            end
            repeat (st) @(negedge clk);
            bus.txReady = 1'b1;
            @(negedge clk);
            bus.reqValid = '0;
            finishFrame($urandom_range(0, 12));
            total++;
            if ({packetCount, busy} !== {16'(expCount), 1'b0}) begin bad++; $display("FAIL rand_done[%0d]: got cnt=%0d busy=%b want cnt=%0d busy=0", it, packetCount, busy, expCount); end
        end
    endtask

    task automatic test_reset_mid;
        int w;
        logic [DW-1:0] ed;
        bus.txReady = 1'b1;
        bus.reqValid = N'($urandom_range(1, 15));
        #1;
        w = rrWin(bus.reqValid);
        ptr = (w + 1) % N;
        @(negedge clk);
        bus.reqValid = '0;
        @(negedge clk);
        total++;
        if ({busy, packetCount} !== {1'b1, 16'(expCount)}) begin bad++; $display("FAIL rst_mid_pre: got busy=%b cnt=%0d want busy=1 cnt=%0d", busy, packetCount, expCount); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.txValid, busy, packetCount, timeoutErr} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: got v=%b busy=%b cnt=%0d to=%b want all 0", bus.txValid, busy, packetCount, timeoutErr);
        end
        ptr = 0;
        expCount = 0;
        @(negedge clk);
        reset = 1'b0;
        bus.reqData = $urandom;
        bus.reqValid = 4'b0100;
        #1;
        w = rrWin(bus.reqValid);
        ed = bus.reqData[w*DW +: DW];
        total++;
        if (bus.reqReady !== 4'b0100) begin bad++; $display("FAIL rst_mid_ready: got %b want 0100", bus.reqReady); end
        ptr = (w + 1) % N;
        @(negedge clk);
        bus.reqValid = '0;
        total++;
        if ({grantId, bus.txData} !== {2'd2, ed}) begin bad++; $display("FAIL rst_mid_grant: got id=%0d d=%h want id=2 d=%h", grantId, bus.txData, ed); end
        @(negedge clk);
        finishFrame(3);
    endtask

    task automatic test_wrap;
        int w;
        bus.txReady = 1'b1;
        bus.reqValid = N'($urandom_range(1, 15));
        #1;
        w = rrWin(bus.reqValid);
        ptr = (w + 1) % N;
        @(negedge clk);
        bus.reqValid = '0;
        @(negedge clk);
        force dut.packetCount = 16'hFFFF;
        #1;
        release dut.packetCount;
        finishFrame(2);
        expCount = 0;
        total++;
        if (packetCount !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %h want 0000", packetCount); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_enable_low;
        test_timeout;
        test_random;
        test_reset_mid;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares a single UART transmitter engine between NUM_REQ independent requesters.
- Round-robin arbitration picks one requester; the scheduler captures its data byte and per-frame parity-error-injection flag.
- It issues the frame to the transmitter, waits for frame completion, then enforces an inter-frame idle gap.
- It counts completed packets and flags frames that fail to complete within a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of the data field per frame.
- GAP_CYCLES, 2, idle clk cycles between frame completion and the next grant (0 allowed).
- TIMEOUT_CYCLES, 4096, maximum clk cycles allowed in WAIT_DONE before abort.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits new grants; an in-flight frame always completes.
- reqValid  input  NUM_REQ  per-requester frame request.
- reqData  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reqParityErrInj  input  NUM_REQ  per-requester parity-error-injection flag.
- reqReady  output  NUM_REQ  one-hot accept; a transfer occurs when reqValid[i] && reqReady[i] at a clk edge.
- txValid  output  1  frame offered to the transmitter.
- txData  output  DATA_WIDTH  captured data.
- txParityErrInj  output  1  captured injection flag.
- txReady  input  1  transmitter accepts; the handshake is txValid && txReady.
- txDone  input  1  single-cycle pulse at the end of the stop bit.
- grantId  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.
- packetCount  output  16  completed frames; wraps 0xFFFF -> 0.
- timeoutErr  output  1  single-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE; rrPtr = 0.
  - reqReady = 0, txValid = 0, txData = 0, txParityErrInj = 0.
  - grantId = 0, busy = 0, packetCount = 0, timeoutErr = 0.
  - Reset mid-frame abandons the frame; nothing is replayed.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - Winner = first i with reqValid[i], scanning rrPtr, rrPtr+1, ..., wrapping modulo NUM_REQ.
  - reqReady[winner] is combinational and high only when state == IDLE && enable && any reqValid.
  - At that edge:
    - Capture reqData/reqParityErrInj of the winner into txData/txParityErrInj.
    - grantId <= winner.
    - rrPtr <= (winner+1) mod NUM_REQ.
    - State -> ISSUE.
  - Latency: request seen in cycle N -> txValid high in cycle N+1.
- ISSUE:
  - txValid = 1; txData and txParityErrInj are held stable.
  - On txValid && txReady: txValid drops the next cycle, timeout counter cleared, state -> WAIT_DONE.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - On txDone: packetCount += 1, state -> GAP (or IDLE if GAP_CYCLES == 0).
  - If the counter reaches TIMEOUT_CYCLES-1 without txDone: timeoutErr pulses one cycle, packetCount is unchanged, state -> GAP/IDLE as above.
  - If txDone arrives in the same cycle as the timeout limit, txDone wins and there is no timeoutErr.
- GAP:
  - Counts GAP_CYCLES cycles, then -> IDLE.
  - A grant is possible in the first IDLE cycle.
- txDone outside WAIT_DONE is ignored.
- reqValid dropped before a grant: no transfer; the requester loses no priority.
- enable low in IDLE: no reqReady.
- enable low in other states: the current sequence finishes and the block parks in IDLE.
- The arbitration pointer advances only on a grant; a non-requesting index never stalls arbitration.
- busy = (state != IDLE).

Test Plan:
- Single request: reqValid=0001, reqData[0]=0xA5, txReady=1, txDone 10 cycles after the handshake -> reqReady=0001 for 1 cycle; txValid next cycle with txData=0xA5; packetCount=1; IDLE reached 2 cycles after txDone.
- Round-robin: all four requesters held valid with data 0x10/0x11/0x12/0x13 -> grant order 0,1,2,3,0; txData sequence 0x10,0x11,0x12,0x13,0x10; a reqReady never repeats before wrap.
- Backpressure: txReady low for 5 cycles in ISSUE -> txValid and txData stable throughout; no second reqReady; the handshake completes on the first txReady high.
- Timeout: TIMEOUT_CYCLES=16, txDone never asserted -> timeoutErr pulses exactly once, 16 cycles after the handshake; packetCount unchanged; the next request is granted.
- Reset mid-frame: assert reset in WAIT_DONE -> txValid=0, busy=0, packetCount=0 in the same cycle (asynchronously); after release, reqValid=0100 -> grant to requester 2.
- Edge cases:
  - packetCount preloaded to 0xFFFF by forced stimulus -> wraps to 0x0000 after the next txDone.
  - enable low with reqValid=1111 -> no reqReady.
